// File: rtl/spi_master_pkg.sv
// rtl/spi_master_pkg.sv - shared widths and word-alignment helpers for the SPI engine
package spi_master_pkg;

  localparam int WORD_W = 16;
  localparam int CNT_W  = 4;

  // Index of the first (most significant) bit sent for the selected width.
  function automatic logic [CNT_W-1:0] first_bit_index(input logic width_16);
    return width_16 ? 4'd15 : 4'd7;
  endfunction

  // Left-justify the transmit word so the outgoing bit is always at [15].
  function automatic logic [WORD_W-1:0] align_tx(input logic [WORD_W-1:0] word,
                                                 input logic width_16);
    return width_16 ? word : {word[7:0], 8'h00};
  endfunction

  // Received bits accumulate from the LSB; 8-bit results are zero-extended.
  function automatic logic [WORD_W-1:0] extend_rx(input logic [WORD_W-1:0] shift,
                                                  input logic width_16);
    return width_16 ? shift : {8'h00, shift[7:0]};
  endfunction

endpackage

// File: rtl/spi_master.sv
// rtl/spi_master.sv - SPI mode 0 master, MSB first, 8/16-bit transfers
module spi_master
  import spi_master_pkg::*;
#(
  parameter int CLOCK_DIV = 4
) (
  input  logic              raw_clk,
  input  logic              reset,
  input  logic              start,
  input  logic              width_16,
  input  logic [WORD_W-1:0] data_tx,
  output logic [WORD_W-1:0] data_rx,
  output logic              busy,
  output logic              done,
  output logic              sclk,
  output logic              mosi,
  input  logic              miso
);

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    SHIFT_LOW  = 2'd1,
    SHIFT_HIGH = 2'd2
  } state_t;

  localparam logic [7:0] DIV_LAST = 8'(CLOCK_DIV - 1);

  state_t              state;
  state_t              state_next;
  logic [7:0]          div_cnt;
  logic [CNT_W-1:0]    bit_cnt;
  logic [WORD_W-2:0]   tx_rest;
  logic [WORD_W-1:0]   rx_shift;
  logic [WORD_W-1:0]   tx_aligned;
  logic                mode_16;
  logic                div_end;
  logic                load;
  logic                rise;
  logic                advance;
  logic                finish;

  assign div_end    = (div_cnt == DIV_LAST);
  assign tx_aligned = align_tx(data_tx, width_16);

  always_ff @(posedge raw_clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    load       = 1'b0;
    rise       = 1'b0;
    advance    = 1'b0;
    finish     = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          load       = 1'b1;
          state_next = SHIFT_LOW;
        end
      end
      SHIFT_LOW: begin
        if (div_end) begin
          rise       = 1'b1;
          state_next = SHIFT_HIGH;
        end
      end
      SHIFT_HIGH: begin
        if (div_end) begin
          if (bit_cnt != '0) begin
            advance    = 1'b1;
            state_next = SHIFT_LOW;
          end else begin
            finish     = 1'b1;
            state_next = IDLE;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Datapath: every phase change restarts the divider from zero.
  always_ff @(posedge raw_clk) begin
    if (reset) begin
      div_cnt  <= '0;
      bit_cnt  <= '0;
      tx_rest  <= '0;
      rx_shift <= '0;
      mode_16  <= 1'b0;
      data_rx  <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      sclk     <= 1'b0;
      mosi     <= 1'b0;
    end else begin
      done <= 1'b0;
      if (load) begin
        mode_16  <= width_16;
        mosi     <= tx_aligned[WORD_W-1];
        tx_rest  <= tx_aligned[WORD_W-2:0];
        rx_shift <= '0;
        bit_cnt  <= first_bit_index(width_16);
        div_cnt  <= '0;
        busy     <= 1'b1;
        sclk     <= 1'b0;
      end else if (rise) begin
        sclk     <= 1'b1;
        rx_shift <= {rx_shift[WORD_W-2:0], miso};
        div_cnt  <= '0;
      end else if (advance) begin
        sclk    <= 1'b0;
        bit_cnt <= bit_cnt - 1'b1;
        mosi    <= tx_rest[WORD_W-2];
        tx_rest <= {tx_rest[WORD_W-3:0], 1'b0};
        div_cnt <= '0;
      end else if (finish) begin
        sclk    <= 1'b0;
        data_rx <= extend_rx(rx_shift, mode_16);
        busy    <= 1'b0;
        done    <= 1'b1;
        mosi    <= 1'b0;
        div_cnt <= '0;
      end else if (state != IDLE) begin
        div_cnt <= div_cnt + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_spi_master.sv
// tb/tb_spi_master.sv - self-checking bench for spi_master at CLOCK_DIV 2 and 1
module tb_spi_master;

  logic        raw_clk = 1'b0;
  logic        reset;
  logic        start    [2];
  logic        width_16 [2];
  logic [15:0] data_tx  [2];
  logic        miso     [2];
  logic [15:0] data_rx  [2];
  logic        busy     [2];
  logic        done     [2];
  logic        sclk     [2];
  logic        mosi     [2];

  int checks   = 0;
  int failures = 0;

  always #5 raw_clk = ~raw_clk;

  spi_master #(.CLOCK_DIV(2)) u_div2 (
    .raw_clk (raw_clk),
    .reset   (reset),
    .start   (start[0]),
    .width_16(width_16[0]),
    .data_tx (data_tx[0]),
    .data_rx (data_rx[0]),
    .busy    (busy[0]),
    .done    (done[0]),
    .sclk    (sclk[0]),
    .mosi    (mosi[0]),
    .miso    (miso[0])
  );

  spi_master #(.CLOCK_DIV(1)) u_div1 (
    .raw_clk (raw_clk),
    .reset   (reset),
    .start   (start[1]),
    .width_16(width_16[1]),
    .data_tx (data_tx[1]),
    .data_rx (data_rx[1]),
    .busy    (busy[1]),
    .done    (done[1]),
    .sclk    (sclk[1]),
    .mosi    (mosi[1]),
    .miso    (miso[1])
  );

  function automatic int cd_of(input int sel);
    return (sel == 0) ? 2 : 1;
  endfunction

  task automatic tick();
    @(posedge raw_clk);
    #1;
  endtask

  // One full transfer; expectations come from the word-level rules only.
  task automatic xfer(input int sel, input logic w16, input logic [15:0] tx,
                      input logic loopback, input logic [15:0] mword,
                      input logic hold, input logic [15:0] tx_mid, input string name);
    int          bits;
    int          expect_cycles;
    int          busy_cyc;
    int          rises;
    int          falls;
    logic [15:0] txw;
    logic [15:0] rxw;
    logic [15:0] mosi_acc;
    logic [15:0] rx_hold;
    logic        prev_sclk;
    logic        ended;
    logic        early_done;
    logic        rx_changed;
    bits          = w16 ? 16 : 8;
    expect_cycles = bits * 2 * cd_of(sel);
    txw           = w16 ? tx : {8'h00, tx[7:0]};
    rxw           = loopback ? txw : (w16 ? mword : {8'h00, mword[7:0]});
    busy_cyc      = 0;
    rises         = 0;
    falls         = 0;
    mosi_acc      = 16'h0000;
    rx_hold       = data_rx[sel];
    ended         = 1'b0;
    early_done    = 1'b0;
    rx_changed    = 1'b0;

    start[sel]    = 1'b1;
    width_16[sel] = w16;
    data_tx[sel]  = tx;
    miso[sel]     = loopback ? mosi[sel] : mword[bits-1];
    tick();
    checks++;
    if (busy[sel] !== 1'b1 || mosi[sel] !== txw[bits-1]) begin
      failures++;
      $display("FAIL %s start: busy=%b mosi=%b expected busy=1 mosi=%b",
               name, busy[sel], mosi[sel], txw[bits-1]);
    end
    if (!hold) start[sel] = 1'b0;
    busy_cyc  = 1;
    prev_sclk = 1'b0;

    for (int cyc = 0; cyc < 4000 && !ended; cyc++) begin
      if (sclk[sel] && !prev_sclk) begin
        rises++;
        mosi_acc = {mosi_acc[14:0], mosi[sel]};
      end
      if (!sclk[sel] && prev_sclk) falls++;
      prev_sclk = sclk[sel];
      if (data_rx[sel] !== rx_hold) rx_changed = 1'b1;
      if (done[sel] !== 1'b0) early_done = 1'b1;
      if (loopback) miso[sel] = mosi[sel];
      else if (falls < bits) miso[sel] = mword[bits-1-falls];
      if (busy_cyc == expect_cycles / 2) begin
        data_tx[sel] = tx_mid;
        if (!hold) width_16[sel] = ~w16;
      end
      tick();
      if (busy[sel] === 1'b1) busy_cyc++;
      else ended = 1'b1;
    end

    checks++;
    if (!ended) begin
      failures++;
      $display("FAIL %s timeout: busy still %b after cycle budget", name, busy[sel]);
    end
    checks++;
    if (busy_cyc != expect_cycles) begin
      failures++;
      $display("FAIL %s busy_len: got %0d expected %0d", name, busy_cyc, expect_cycles);
    end
    checks++;
    if (rises != bits) begin
      failures++;
      $display("FAIL %s sclk_rises: got %0d expected %0d", name, rises, bits);
    end
    checks++;
    if (mosi_acc !== txw) begin
      failures++;
      $display("FAIL %s mosi_bits: got %h expected %h", name, mosi_acc, txw);
    end
    checks++;
    if (data_rx[sel] !== rxw) begin
      failures++;
      $display("FAIL %s data_rx: got %h expected %h", name, data_rx[sel], rxw);
    end
    checks++;
    if (done[sel] !== 1'b1 || early_done || rx_changed) begin
      failures++;
      $display("FAIL %s done: done=%b early_done=%b rx_changed=%b expected 1 0 0",
               name, done[sel], early_done, rx_changed);
    end
    checks++;
    if (sclk[sel] !== 1'b0 || mosi[sel] !== 1'b0) begin
      failures++;
      $display("FAIL %s idle_lines: sclk=%b mosi=%b expected 0 0", name, sclk[sel], mosi[sel]);
    end
    if (!hold) begin
      tick();
      checks++;
      if (done[sel] !== 1'b0 || busy[sel] !== 1'b0) begin
        failures++;
        $display("FAIL %s after_done: done=%b busy=%b expected 0 0", name, done[sel], busy[sel]);
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    for (int s = 0; s < 2; s++) begin
      start[s]    = 1'b1;
      width_16[s] = 1'b1;
      data_tx[s]  = 16'hFFFF;
      miso[s]     = 1'b1;
    end
    tick();
    tick();
    for (int s = 0; s < 2; s++) begin
      checks++;
      if (busy[s] !== 1'b0 || done[s] !== 1'b0 || sclk[s] !== 1'b0 ||
          mosi[s] !== 1'b0 || data_rx[s] !== 16'h0000) begin
        failures++;
        $display("FAIL reset_state[%0d]: busy=%b done=%b sclk=%b mosi=%b data_rx=%h expected all 0",
                 s, busy[s], done[s], sclk[s], mosi[s], data_rx[s]);
      end
      start[s] = 1'b0;
    end
    reset = 1'b0;
    tick();
    for (int s = 0; s < 2; s++) begin
      checks++;
      if (busy[s] !== 1'b0) begin
        failures++;
        $display("FAIL reset_idle[%0d]: busy=%b expected 0", s, busy[s]);
      end
    end
  endtask

  task automatic test_loopback_8();
    xfer(0, 1'b0, 16'h00A5, 1'b1, 16'h0000, 1'b0, 16'h5A5A, "loopback_8");
  endtask

  task automatic test_word_16_div1();
    xfer(1, 1'b1, 16'hBEEF, 1'b0, 16'h1234, 1'b0, 16'h0F0F, "word_16_div1");
  endtask

  task automatic test_byte_upper_ignored();
    xfer(0, 1'b0, 16'hFF3C, 1'b0, 16'hFFFF, 1'b0, 16'h1111, "byte_upper");
  endtask

  task automatic test_random();
    for (int i = 0; i < 8; i++) begin
      xfer(int'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 16'($urandom),
           1'($urandom_range(0, 1)), 16'($urandom), 1'b0, 16'($urandom), "random");
      repeat ($urandom_range(0, 3)) tick();
    end
  endtask

  task automatic test_back_to_back();
    xfer(0, 1'b0, 16'h0011, 1'b1, 16'h0000, 1'b1, 16'h0022, "b2b_first");
    xfer(0, 1'b0, 16'h0022, 1'b1, 16'h0000, 1'b0, 16'h0033, "b2b_second");
  endtask

  task automatic test_reset_abort();
    int   rises;
    logic prev;
    logic seen_done;
    rises     = 0;
    prev      = 1'b0;
    seen_done = 1'b0;
    start[0]    = 1'b1;
    width_16[0] = 1'b1;
    data_tx[0]  = 16'($urandom);
    miso[0]     = 1'b1;
    tick();
    start[0] = 1'b0;
    for (int c = 0; c < 1000 && rises < 5; c++) begin
      if (sclk[0] && !prev) rises++;
      prev = sclk[0];
      if (rises < 5) tick();
    end
    checks++;
    if (rises != 5) begin
      failures++;
      $display("FAIL abort_reach: rises=%0d expected 5", rises);
    end
    reset = 1'b1;
    tick();
    checks++;
    if (sclk[0] !== 1'b0 || busy[0] !== 1'b0 || done[0] !== 1'b0 || data_rx[0] !== 16'h0000) begin
      failures++;
      $display("FAIL abort_state: sclk=%b busy=%b done=%b data_rx=%h expected 0 0 0 0000",
               sclk[0], busy[0], done[0], data_rx[0]);
    end
    reset = 1'b0;
    for (int c = 0; c < 80; c++) begin
      tick();
      if (done[0] !== 1'b0 || busy[0] !== 1'b0) seen_done = 1'b1;
    end
    checks++;
    if (seen_done) begin
      failures++;
      $display("FAIL abort_quiet: done or busy seen after abort, expected none");
    end
    xfer(0, 1'b1, 16'($urandom), 1'b1, 16'h0000, 1'b0, 16'($urandom), "after_abort");
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_loopback_8();
    test_word_16_div1();
    test_byte_upper_ignored();
    test_random();
    test_back_to_back();
    test_reset_abort();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
